// File: rtl/siu_niu_mon_pkg.sv
// Shared types, error-bit indices and helpers for the SIU->NIU outbound packet checker.
package siu_niu_mon_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_e;

    localparam int ERR_OVERLAP = 0;
    localparam int ERR_ORPHAN  = 1;
    localparam int ERR_PARITY  = 2;

    localparam int MAX_CNT_W = 64;

    // Callers zero-extend into MAX_CNT_W and pass their own all-ones ceiling.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] cnt,
        input logic [MAX_CNT_W-1:0] max_val
    );
        return (cnt >= max_val) ? cnt : cnt + 64'd1;
    endfunction

endpackage

// File: rtl/siu_niu_par_chk.sv
// Per-lane parity check: lane i covers DATA_W/PAR_W data bits; mismatch if any lane disagrees.
module siu_niu_par_chk #(
    parameter int DATA_W  = 128,
    parameter int PAR_W   = 8,
    parameter int PAR_ODD = 0
) (
    input  logic [DATA_W-1:0] data,
    input  logic [PAR_W-1:0]  parity,
    output logic              mismatch
);

    localparam int LANE_W = DATA_W / PAR_W;

    logic [PAR_W-1:0] expected;

    always_comb begin
        for (int i = 0; i < PAR_W; i++) begin
            expected[i] = (^data[i*LANE_W +: LANE_W]) ^ (PAR_ODD != 0);
        end
    end

    assign mismatch = |(expected ^ parity);

endmodule

// File: rtl/siu_niu_pkt_checker.sv
// Passive SIO->NIU outbound monitor: tracks header/payload sequencing, checks lane parity,
// counts clean packets and reports errors as registered pulses plus sticky status.
module siu_niu_pkt_checker
    import siu_niu_mon_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int PAR_W   = 8,
    parameter int BEATS   = 4,
    parameter int PAR_ODD = 0,
    parameter int CNT_W   = 16
) (
    input  logic              iol2clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sio_niu_hdr_vld,
    input  logic              sio_niu_datareq,
    input  logic [DATA_W-1:0] sio_niu_data,
    input  logic [PAR_W-1:0]  sio_niu_parity,
    input  logic              clr_sticky,
    output logic              pkt_done,
    output logic [2:0]        err_pulse,
    output logic [2:0]        err_sticky,
    output logic [CNT_W-1:0]  data_pkt_cnt,
    output logic [CNT_W-1:0]  ack_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [DATA_W-1:0] last_hdr,
    output logic              busy
);

    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0]    BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [MAX_CNT_W-1:0] CNT_MAX   = MAX_CNT_W'({CNT_W{1'b1}});

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              pkt_err_q, pkt_err_d;
    logic              par_err;
    logic              done_d;
    logic [2:0]        err_d;
    logic              hdr_load;
    logic              inc_data;
    logic              inc_ack;

    siu_niu_par_chk #(
        .DATA_W (DATA_W),
        .PAR_W  (PAR_W),
        .PAR_ODD(PAR_ODD)
    ) u_par_chk (
        .data    (sio_niu_data),
        .parity  (sio_niu_parity),
        .mismatch(par_err)
    );

    // NOTE: every signal gets a default before any branch so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        pkt_err_d = pkt_err_q;
        done_d    = 1'b0;
        err_d     = '0;
        hdr_load  = 1'b0;
        inc_data  = 1'b0;
        inc_ack   = 1'b0;

        if (!enable) begin
            state_d   = IDLE;
            beat_d    = '0;
            pkt_err_d = 1'b0;
        end else if (sio_niu_hdr_vld) begin
            // A header inside a payload aborts the old packet and starts fresh.
            hdr_load             = 1'b1;
            err_d[ERR_OVERLAP]   = (state_q == PAYLOAD);
            err_d[ERR_PARITY]    = par_err;
            beat_d               = '0;
            if (sio_niu_datareq) begin
                state_d   = PAYLOAD;
                pkt_err_d = par_err;
            end else begin
                state_d   = IDLE;
                pkt_err_d = 1'b0;
                done_d    = !par_err;
                inc_ack   = !par_err;
            end
        end else if (state_q == PAYLOAD) begin
            err_d[ERR_PARITY] = par_err;
            if (beat_q == BEAT_LAST) begin
                state_d   = IDLE;
                beat_d    = '0;
                pkt_err_d = 1'b0;
                done_d    = !(pkt_err_q || par_err);
                inc_data  = !(pkt_err_q || par_err);
            end else begin
                beat_d    = beat_q + 1'b1;
                pkt_err_d = pkt_err_q | par_err;
            end
        end else if (sio_niu_datareq) begin
            err_d[ERR_ORPHAN] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge iol2clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            pkt_err_q    <= 1'b0;
            pkt_done     <= 1'b0;
            err_pulse    <= '0;
            err_sticky   <= '0;
            data_pkt_cnt <= '0;
            ack_cnt      <= '0;
            err_cnt      <= '0;
            // NOTE: the wide header register is reset too, since it is a visible output.
            last_hdr     <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            pkt_err_q <= pkt_err_d;
            pkt_done  <= done_d;
            err_pulse <= err_d;
            if (enable) begin
                err_sticky <= (err_sticky | err_d) & ~{3{clr_sticky}};
                if (hdr_load) last_hdr <= sio_niu_data;
                if (inc_data) data_pkt_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(data_pkt_cnt), CNT_MAX));
                if (inc_ack)  ack_cnt      <= CNT_W'(sat_inc(MAX_CNT_W'(ack_cnt), CNT_MAX));
                if (|err_d)   err_cnt      <= CNT_W'(sat_inc(MAX_CNT_W'(err_cnt), CNT_MAX));
            end
        end
    end

    assign busy = (state_q == PAYLOAD);

endmodule
